fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Parametrised frame/burst controller for the R22SDF FFT core's AXI-Stream wrapper. It latches point size and burst count on a start edge and gates the slave input stream frame by frame. It checks input TLAST placement against the configured point size and counts output frames until the whole burst has drained. It reports busy, done, input/output progress and error status to the PS.

## Interface
- PT_W, 11: width of point-size field and per-frame beat counter (max point 2^PT_W-1)
- BURST_W, 10: width of burst (frame count) field and frame counters
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_start  in  1  PS start level; rising edge requests a run
- i_abort  in  1  PS abort; level, sampled every cycle
- i_point  in  PT_W  samples per frame; latched on accepted start
- i_burst  in  BURST_W  frames per run; latched on accepted start
- s_axis_tvalid  in  1  slave valid
- s_axis_tlast  in  1  slave last
- s_axis_tready  out  1  slave ready (combinational from state)
- m_axis_tvalid  in  1  master valid (monitored)
- m_axis_tready  in  1  master ready (monitored)
- m_axis_tlast  in  1  master last (monitored)
- o_point  out  PT_W  latched point size to FFT core
- o_busy  out  1  high in LOAD or RUN
- o_done  out  1  one-cycle pulse on burst completion
- o_err_tlast  out  1  sticky input TLAST mismatch
- o_err_cfg  out  1  sticky: start rejected (i_point<2 or i_burst==0)
- o_in_frames  out  BURST_W  input frames fully accepted this run
- o_out_frames  out  BURST_W  output frames completed this run

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Start edge: start_d register (reset 0) tracks i_start; edge = i_start & ~start_d. Honoured only in IDLE; edges in other states are ignored.
- IDLE + edge + valid config (i_point>=2, i_burst!=0): latch point/burst, clear counters and o_err_tlast and o_err_cfg, go to LOAD.
- IDLE + edge + invalid config: stay in IDLE, set o_err_cfg, leave the latched config unchanged.
- LOAD: s_axis_tready=1. Each accepted beat (tvalid&tready) increments beat_cnt.
  - Beat at beat_cnt==point-1 ends the frame: beat_cnt->0, o_in_frames+1.
  - Frame boundary is set by the count only, never by TLAST.
  - TLAST high at beat_cnt!=point-1, or low at beat_cnt==point-1, sets o_err_tlast. That beat is still accepted.
- LOAD -> RUN on the cycle the final beat of frame i_burst is accepted.
- Output counting (LOAD and RUN): m_axis_tvalid&m_axis_tready&m_axis_tlast increments o_out_frames. Counting saturates at the latched burst; extra TLASTs are ignored.
- RUN: s_axis_tready=0. RUN -> DONE when an output TLAST handshake brings o_out_frames to burst.
- If the output completion coincides with the final input beat in LOAD: go to RUN. DONE follows once o_out_frames==burst, checked the next cycle.
- DONE: o_done=1 for one cycle, then IDLE. o_point, the counters and the error flags hold their values in IDLE until the next accepted start.
- i_abort in LOAD/RUN/DONE: next state IDLE.
  - beat_cnt cleared. No o_done pulse.
  - Counters and flags hold for PS readout.
  - i_abort in IDLE has no effect.
  - Abort beats a simultaneous transition.
- Arithmetic: compare beat_cnt against point-1 computed in PT_W bits. Frame counters never wrap because they saturate at burst.

## Timing
- Reset: state IDLE, start_d=0, beat_cnt=0.
- Output reset values: o_point=0, counters=0, o_busy=0, o_done=0, both error flags=0, s_axis_tready=0.
- Edge sampled in cycle N: state=LOAD and s_axis_tready=1 in N+1. First beat can be accepted in N+1.
- o_busy, o_done, o_err_*, o_in_frames, o_out_frames are registered; they update the cycle after the causing event.
- s_axis_tready drops in the cycle after the final input beat is accepted; no extra beat is ever accepted.
- o_done is high exactly one cycle, which is the DONE state.
- Reset mid-run forces all reset values on the next edge, regardless of other inputs.

## Test plan
- point=16, burst=2: start edge, 32 beats with TLAST on beats 15 and 31, two output TLASTs.
  - o_in_frames=2, tready low after beat 31.
  - o_done one pulse after the 2nd output TLAST.
  - o_err_tlast=0, o_busy low after DONE.
- point=8, burst=1: TLAST on beat 5 and none on beat 7.
  - o_err_tlast=1 from the cycle after beat 5; frame still ends at beat 7.
  - o_in_frames=1, run completes normally.
- Start with i_burst=0: o_err_cfg=1, state stays IDLE, tready=0. A following valid start clears o_err_cfg.
- point=16, burst=4: assert i_abort after 20 input beats.
  - IDLE next cycle, o_busy=0, no o_done pulse.
  - o_in_frames=1 holds; a new start restarts from zero.
- Hold i_start high across a full run: no second run starts. A second run requires i_start low then high.
- Continuous tvalid with back-to-back frames (point=4, burst=3): 12 consecutive accepted beats, no bubbles, then tready=0. Extra output TLASTs beyond 3 leave o_out_frames=3.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frame/burst controller for the R22SDF FFT AXI-Stream wrapper: latches point/burst on a start edge,
// gates input frames by beat count, flags TLAST misplacement and counts output frames until drained.
module fft_frame_ctrl #(
    parameter int PT_W    = 11,
    parameter int BURST_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [PT_W-1:0]    i_point,
    input  logic [BURST_W-1:0] i_burst,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    input  logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    input  logic               m_axis_tlast,
    output logic [PT_W-1:0]    o_point,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err_tlast,
    output logic               o_err_cfg,
    output logic [BURST_W-1:0] o_in_frames,
    output logic [BURST_W-1:0] o_out_frames
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [PT_W-1:0]    point_q, point_d, beat_q, beat_d;
    logic [BURST_W-1:0] burst_q, burst_d, in_q, in_d, out_q, out_d;
    logic               err_tlast_q, err_tlast_d, err_cfg_q, err_cfg_d;
    logic               start_edge, cfg_ok, in_hs, last_beat, out_hs;

    assign start_edge = i_start & ~start_q;
    assign cfg_ok     = (i_point >= PT_W'(2)) && (i_burst != '0);
    assign in_hs      = s_axis_tvalid & s_axis_tready;
    assign last_beat  = (beat_q == point_q - PT_W'(1));
    // Output frame count saturates at the latched burst; stray TLASTs are ignored.
    assign out_hs     = m_axis_tvalid & m_axis_tready & m_axis_tlast
                      & ((state_q == LOAD) || (state_q == RUN))
                      & (out_q != burst_q);

    always_comb begin
        state_d     = state_q;
        point_d     = point_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        in_d        = in_q;
        out_d       = out_q;
        err_tlast_d = err_tlast_q;
        err_cfg_d   = err_cfg_q;

        if (out_hs) begin
            out_d = out_q + BURST_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    if (cfg_ok) begin
                        point_d     = i_point;
                        burst_d     = i_burst;
                        beat_d      = '0;
                        in_d        = '0;
                        out_d       = '0;
                        err_tlast_d = 1'b0;
                        err_cfg_d   = 1'b0;
                        state_d     = LOAD;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_hs) begin
                    // Frame boundary comes from the count; TLAST is only checked.
                    if (s_axis_tlast != last_beat) begin
                        err_tlast_d = 1'b1;
                    end
                    if (last_beat) begin
                        beat_d = '0;
                        in_d   = in_q + BURST_W'(1);
                        if (in_q + BURST_W'(1) == burst_q) begin
                            state_d = RUN;
                        end
                    end else begin
                        beat_d = beat_q + PT_W'(1);
                    end
                end
            end
            RUN: begin
                if (out_d == burst_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (i_abort && (state_q != IDLE)) begin
            state_d = IDLE;
            beat_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            point_q     <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            in_q        <= '0;
            out_q       <= '0;
            err_tlast_q <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= i_start;
            point_q     <= point_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            in_q        <= in_d;
            out_q       <= out_d;
            err_tlast_q <= err_tlast_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    assign s_axis_tready = (state_q == LOAD);
    assign o_busy        = (state_q == LOAD) || (state_q == RUN);
    assign o_done        = (state_q == DONE);
    assign o_point       = point_q;
    assign o_err_tlast   = err_tlast_q;
    assign o_err_cfg     = err_cfg_q;
    assign o_in_frames   = in_q;
    assign o_out_frames  = out_q;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized scoreboard bench for fft_frame_ctrl: drivers push expected events per run,
// a monitor pops and compares them when the DUT shows start, error, end or config-error events.
module tb_fft_frame_ctrl;
    localparam int PT_W    = 11;
    localparam int BURST_W = 10;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               i_start = 1'b0, i_abort = 1'b0;
    logic [PT_W-1:0]    i_point = '0;
    logic [BURST_W-1:0] i_burst = '0;
    logic               s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic               m_axis_tvalid = 1'b0, m_axis_tready = 1'b0, m_axis_tlast = 1'b0;
    logic [PT_W-1:0]    o_point;
    logic               o_busy, o_done, o_err_tlast, o_err_cfg;
    logic [BURST_W-1:0] o_in_frames, o_out_frames;

    fft_frame_ctrl #(.PT_W(PT_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
        .i_point(i_point), .i_burst(i_burst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .o_point(o_point), .o_busy(o_busy), .o_done(o_done), .o_err_tlast(o_err_tlast),
        .o_err_cfg(o_err_cfg), .o_in_frames(o_in_frames), .o_out_frames(o_out_frames)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc; int point; int in_fr; int out_fr; int err; int done; int beats; int span;
    } exp_t;

    exp_t st_q[$], er_q[$], en_q[$], cf_q[$];
    bit   corr_q[$];
    int   checks = 0, failures = 0;
    int   last_point = 0;

    function automatic void chk(string name, longint act, longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic void evfail(string name);
        checks++;
        failures++;
        $display("FAIL %s: DUT event with no expected entry (cycle %0d)", name, cyc);
    endfunction

    function automatic exp_t mk(int c, int p, int inf, int outf, int e, int d, int b, int s);
        exp_t r;
        r.cyc = c; r.point = p; r.in_fr = inf; r.out_fr = outf;
        r.err = e; r.done = d; r.beats = b; r.span = s;
        return r;
    endfunction

    // ---------------- monitor ----------------
    logic prev_rst = 1'b0, prev2_rst = 1'b0, prev_busy = 1'b0;
    logic prev_errt = 1'b0, prev_errc = 1'b0, prev_done = 1'b0;
    int   beats = 0, first_hs = -1, last_hs = -1;
    exp_t me;

    always @(negedge clk) begin
        if (prev_rst && !prev2_rst) begin
            chk("rst_point", o_point, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_err_tlast", o_err_tlast, 0);
            chk("rst_err_cfg", o_err_cfg, 0);
            chk("rst_in_frames", o_in_frames, 0);
            chk("rst_out_frames", o_out_frames, 0);
            chk("rst_tready", s_axis_tready, 0);
        end
        if (prev_rst) begin
            beats = 0; first_hs = -1; last_hs = -1;
        end else begin
            if (o_busy && !prev_busy) begin
                if (st_q.size() == 0) evfail("start_event");
                else begin
                    me = st_q.pop_front();
                    chk("start_cycle", cyc, me.cyc);
                    chk("start_point", o_point, me.point);
                    chk("start_in_frames", o_in_frames, 0);
                    chk("start_out_frames", o_out_frames, 0);
                    chk("start_err_tlast", o_err_tlast, 0);
                    chk("start_err_cfg", o_err_cfg, 0);
                    chk("start_tready", s_axis_tready, 1);
                end
                beats = 0; first_hs = -1; last_hs = -1;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                chk("hs_only_when_busy", o_busy, 1);
                beats++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (o_err_tlast && !prev_errt) begin
                if (er_q.size() == 0) evfail("err_tlast_event");
                else begin
                    me = er_q.pop_front();
                    chk("err_tlast_cycle", cyc, me.cyc);
                end
            end
            if (!o_busy && prev_busy) begin
                if (en_q.size() == 0) evfail("end_event");
                else begin
                    me = en_q.pop_front();
                    if (me.cyc >= 0) chk("end_cycle", cyc, me.cyc);
                    chk("end_done", o_done, me.done);
                    chk("end_in_frames", o_in_frames, me.in_fr);
                    chk("end_out_frames", o_out_frames, me.out_fr);
                    chk("end_err_tlast", o_err_tlast, me.err);
                    chk("end_beats_accepted", beats, me.beats);
                    chk("end_point", o_point, me.point);
                    if (me.span >= 0) chk("end_beat_span", last_hs - first_hs, me.span);
                end
            end
            if (o_err_cfg && !prev_errc) begin
                if (cf_q.size() == 0) evfail("err_cfg_event");
                else begin
                    me = cf_q.pop_front();
                    chk("cfg_cycle", cyc, me.cyc);
                    chk("cfg_busy", o_busy, 0);
                    chk("cfg_tready", s_axis_tready, 0);
                    chk("cfg_point_kept", o_point, me.point);
                end
            end
            if (prev_done) chk("done_one_cycle", o_done, 0);
        end
        prev2_rst = prev_rst;
        prev_rst  = reset;
        prev_busy = o_busy;
        prev_errt = o_err_tlast;
        prev_errc = o_err_cfg;
        prev_done = o_done;
    end

    // ---------------- drivers ----------------
    task automatic start_run(int p, int b);
        st_q.push_back(mk(cyc + 1, p, 0, 0, 0, 0, 0, -1));
        i_point = PT_W'(p);
        i_burst = BURST_W'(b);
        i_start = 1'b1;
        last_point = p;
        @(posedge clk); #1;
    endtask

    task automatic drive_in(int p, int n, bit cont, bit tail);
        int  g = 0, guard = 0;
        bit  seen = 1'b0;
        while (g < n && guard < 4000) begin
            s_axis_tvalid = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
            s_axis_tlast  = (((g % p) == p - 1) ? 1'b1 : 1'b0) ^ corr_q[g];
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) begin
                if (corr_q[g] && !seen) begin
                    er_q.push_back(mk(cyc + 1, 0, 0, 0, 1, 0, 0, -1));
                    seen = 1'b1;
                end
                g++;
            end
            @(posedge clk); #1;
            guard++;
        end
        chk("in_beats_driven", g, n);
        if (tail) begin
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drive_out(int n, bit fast);
        int sent = 0, guard = 0;
        while (sent < n && guard < 4000) begin
            m_axis_tvalid = fast ? 1'b1 : 1'($urandom_range(0, 1));
            m_axis_tready = fast ? 1'b1 : 1'($urandom_range(0, 1));
            m_axis_tlast  = fast ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) sent++;
            @(posedge clk); #1;
            guard++;
        end
        m_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        m_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (o_busy && g < 1000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("run_reaches_idle", o_busy, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // corr_pct < 0 keeps a hand-built corr_q
    task automatic do_run(int p, int b, int nout, bit cont, int corr_pct, bit hold);
        int n = p * b;
        int errs = 0;
        if (corr_pct >= 0) begin
            corr_q.delete();
            for (int g = 0; g < n; g++) corr_q.push_back($urandom_range(0, 99) < corr_pct);
        end
        foreach (corr_q[k]) if (k < n && corr_q[k]) errs = 1;
        start_run(p, b);
        en_q.push_back(mk(-1, p, b, (nout < b) ? nout : b, errs, 1, n, cont ? n - 1 : -1));
        if (!hold) i_start = 1'b0;
        fork
            drive_in(p, n, cont, 1'b1);
            drive_out(nout, cont);
        join
        wait_idle();
        if (hold) begin
            repeat (20) @(posedge clk);
            #1;
        end
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cfg_reject(int p, int b);
        cf_q.push_back(mk(cyc + 1, last_point, 0, 0, 0, 0, 0, -1));
        i_point = PT_W'(p);
        i_burst = BURST_W'(b);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // point=16, burst=2, correct TLASTs
        do_run(16, 2, 2, 1'b0, 0, 1'b0);

        // point=8, burst=1: TLAST early on beat 5, missing on beat 7
        corr_q.delete();
        for (int g = 0; g < 8; g++) corr_q.push_back(1'b0);
        corr_q[5] = 1'b1;
        corr_q[7] = 1'b1;
        do_run(8, 1, 1, 1'b0, -1, 1'b0);

        // rejected configs, each followed by a valid start that clears the flag
        cfg_reject(16, 0);
        do_run(4, 2, 2, 1'b0, 0, 1'b0);
        cfg_reject(1, 3);
        do_run(3, 1, 2, 1'b0, 0, 1'b0);

        // abort after 20 of 64 input beats, one output frame already seen
        start_run(16, 4);
        i_start = 1'b0;
        corr_q.delete();
        for (int g = 0; g < 64; g++) corr_q.push_back(1'b0);
        drive_out(1, 1'b0);
        drive_in(16, 20, 1'b0, 1'b0);
        en_q.push_back(mk(cyc + 1, 16, 20 / 16, 1, 0, 0, 20, -1));
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        do_run(4, 2, 2, 1'b0, 0, 1'b0);

        // i_start held high through and after a run
        do_run(6, 2, 3, 1'b0, 0, 1'b1);

        // back-to-back frames with extra output TLASTs
        do_run(4, 3, 5, 1'b1, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int p = $urandom_range(2, 12);
            int b = $urandom_range(1, 4);
            do_run(p, b, b + $urandom_range(0, 2), 1'b0, 10, 1'b0);
        end

        // reset in the middle of a run
        start_run(16, 2);
        i_start = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        s_axis_tvalid = 1'b0;
        last_point = 0;
        repeat (3) @(posedge clk);
        #1;
        do_run(5, 2, 2, 1'b0, 0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("left_start", st_q.size(), 0);
        chk("left_err", er_q.size(), 0);
        chk("left_end", en_q.size(), 0);
        chk("left_cfg", cf_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
